// File: rtl/snn_pkg.sv
// Types shared by the SNN learning blocks: weight/address widths, the signed
// delta, the queued update request and the weight-update FSM encoding.
package snn_pkg;
  localparam int WEIGHT_W = 8;
  localparam int ADDR_W   = 8;

  typedef logic [WEIGHT_W-1:0]        weight_t;
  typedef logic [ADDR_W-1:0]          addr_t;
  typedef logic signed [WEIGHT_W-1:0] delta_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } upd_state_t;

  typedef struct packed {
    addr_t  addr;
    delta_t delta;
  } upd_req_t;

  localparam int REQ_W = $bits(upd_req_t);

  // Two guard bits keep an unsigned weight plus a signed delta from ever overflowing.
  function automatic logic signed [WEIGHT_W+1:0] weight_sum(weight_t w, delta_t d);
    return $signed({2'b00, w}) + $signed({{2{d[WEIGHT_W-1]}}, d});
  endfunction
endpackage

// File: rtl/synapse_weight_updater_if.sv
// Valid/ready channel carrying weight-update requests into the updater.
interface synapse_weight_updater_if;
  import snn_pkg::*;

  logic   upd_valid;
  logic   upd_ready;
  addr_t  upd_addr;
  delta_t upd_delta;

  modport master (output upd_valid, upd_addr, upd_delta, input upd_ready);
  modport slave  (input upd_valid, upd_addr, upd_delta, output upd_ready);
endinterface

// File: rtl/stdp_update_fifo.sv
// Small synchronous FIFO buffering update requests; DEPTH must be a power of two.
module stdp_update_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_full   = (r_count == (PW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_data   = r_mem[r_rdPtr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end
endmodule

// File: rtl/synapse_weight_updater.sv
// Synapse weight store with a queued read-modify-write update path (IDLE/READ/WRITE),
// a registered inference read port and wrap-around statistics counters.
module synapse_weight_updater
  import snn_pkg::*;
#(
  parameter int      N_SYN       = 256,
  parameter int      FIFO_DEPTH  = 4,
  parameter weight_t INIT_WEIGHT = 8'd128,
  parameter weight_t W_MIN       = 8'd0,
  parameter weight_t W_MAX       = 8'd255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  synapse_weight_updater_if.slave        upd,
  input  addr_t                          rd_addr,
  output weight_t                        rd_data,
  output logic                           busy,
  output logic [31:0]                    applied_count,
  output logic [31:0]                    sat_count,
  output logic [31:0]                    oor_count
);
  upd_state_t                 r_state;
  upd_state_t                 w_nextState;
  upd_req_t                   w_head;
  upd_req_t                   r_req;
  weight_t                    r_oldW;
  weight_t                    w_newW;
  weight_t                    r_mem [N_SYN];
  logic signed [WEIGHT_W+1:0] w_sum;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;
  logic                       w_satHi;
  logic                       w_reqInRange;
  logic                       w_rdInRange;

  stdp_update_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (upd.upd_valid),
    .i_data  ({upd.upd_addr, upd.upd_delta}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign upd.upd_ready = !w_full;
  assign busy          = !w_empty || (r_state != ST_IDLE);
  assign w_reqInRange  = 32'(r_req.addr) < 32'(N_SYN);
  assign w_rdInRange   = 32'(rd_addr) < 32'(N_SYN);
  assign w_sum         = weight_sum(r_oldW, r_req.delta);

  // Only the upper clamp counts as saturation; flooring at W_MIN is silent.
  always_comb begin
    w_newW  = w_sum[WEIGHT_W-1:0];
    w_satHi = 1'b0;
    if (w_sum < $signed({2'b00, W_MIN})) begin
      w_newW = W_MIN;
    end else if (w_sum > $signed({2'b00, W_MAX})) begin
      w_newW  = W_MAX;
      w_satHi = 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextState = ST_READ;
        end
      end
      ST_READ:  w_nextState = ST_WRITE;
      ST_WRITE: w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      r_oldW        <= '0;
      applied_count <= '0;
      sat_count     <= '0;
      oor_count     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_pop) r_req <= w_head;
      if (r_state == ST_READ) r_oldW <= w_reqInRange ? r_mem[r_req.addr] : '0;
      if (r_state == ST_WRITE) begin
        if (w_reqInRange) begin
          applied_count <= applied_count + 32'd1;
          if (w_satHi) sat_count <= sat_count + 32'd1;
        end else begin
          oor_count <= oor_count + 32'd1;
        end
      end
    end
  end

  // rd_data samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYN; i++) r_mem[i] <= INIT_WEIGHT;
      rd_data <= '0;
    end else begin
      if ((r_state == ST_WRITE) && w_reqInRange) r_mem[r_req.addr] <= w_newW;
      rd_data <= w_rdInRange ? r_mem[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_synapse_weight_updater.sv
// Drives two updaters (default and narrowed N_SYN/clamps) with one request stream and
// checks them against a plain-arithmetic weight/counter model.
module tb_synapse_weight_updater;
  import snn_pkg::*;

  localparam int      N_SYN_B = 200;
  localparam weight_t W_MIN_B = 8'd20;
  localparam weight_t W_MAX_B = 8'd230;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  addr_t       rdAddrA, rdAddrB;
  weight_t     rdDataA, rdDataB;
  logic        busyA, busyB;
  logic [31:0] appliedA, satA, oorA, appliedB, satB, oorB;

  int modelA [256];
  int modelB [256];
  int expAppliedA, expSatA, expOorA, expAppliedB, expSatB, expOorB;
  int numCompared = 0;
  int numMismatched = 0;

  logic [7:0] burstAddr [8];
  logic [7:0] burstDelta [8];

  synapse_weight_updater_if ifA ();
  synapse_weight_updater_if ifB ();

  synapse_weight_updater dutA (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd           (ifA),
    .rd_addr       (rdAddrA),
    .rd_data       (rdDataA),
    .busy          (busyA),
    .applied_count (appliedA),
    .sat_count     (satA),
    .oor_count     (oorA)
  );

  synapse_weight_updater #(
    .N_SYN (N_SYN_B),
    .W_MIN (W_MIN_B),
    .W_MAX (W_MAX_B)
  ) dutB (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd           (ifB),
    .rd_addr       (rdAddrB),
    .rd_data       (rdDataB),
    .busy          (busyB),
    .applied_count (appliedB),
    .sat_count     (satB),
    .oor_count     (oorB)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) begin
      modelA[i] = 128;
      modelB[i] = (i < N_SYN_B) ? 128 : 0;
    end
    expAppliedA = 0; expSatA = 0; expOorA = 0;
    expAppliedB = 0; expSatB = 0; expOorB = 0;
  endtask

  task automatic modelApply(input logic [7:0] a, input logic [7:0] d);
    int dv;
    int s;
    dv = int'($signed(d));
    s = modelA[a] + dv;
    if (s < 0) s = 0;
    else if (s > 255) begin s = 255; expSatA++; end
    modelA[a] = s;
    expAppliedA++;
    if (int'(a) >= N_SYN_B) begin
      expOorB++;
    end else begin
      s = modelB[a] + dv;
      if (s < int'(W_MIN_B)) s = int'(W_MIN_B);
      else if (s > int'(W_MAX_B)) begin s = int'(W_MAX_B); expSatB++; end
      modelB[a] = s;
      expAppliedB++;
    end
  endtask

  task automatic driveBus(input logic v, input logic [7:0] a, input logic [7:0] d);
    ifA.upd_valid = v; ifA.upd_addr = a; ifA.upd_delta = d;
    ifB.upd_valid = v; ifB.upd_addr = a; ifB.upd_delta = d;
  endtask

  // Returns #1 after the acceptance edge with the bus released.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    driveBus(1'b1, a, d);
    while (!(ifA.upd_ready && ifB.upd_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("pushAcceptedInTime", 32'(n < 50), 32'd1);
    if (n < 50) begin
      @(posedge clk); #1;
      modelApply(a, d);
    end
    driveBus(1'b0, 8'd0, 8'd0);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((busyA || busyB) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".appliedA"}, appliedA, 32'(expAppliedA));
    checkOutput({tag, ".satA"},     satA,     32'(expSatA));
    checkOutput({tag, ".oorA"},     oorA,     32'(expOorA));
    checkOutput({tag, ".appliedB"}, appliedB, 32'(expAppliedB));
    checkOutput({tag, ".satB"},     satB,     32'(expSatB));
    checkOutput({tag, ".oorB"},     oorB,     32'(expOorB));
  endtask

  task automatic readCheck(input logic [7:0] a);
    rdAddrA = a;
    rdAddrB = a;
    @(posedge clk); #1;
    checkOutput($sformatf("weightA[%0d]", a), 32'(rdDataA), 32'(modelA[a]));
    checkOutput($sformatf("weightB[%0d]", a), 32'(rdDataB), 32'(modelB[a]));
  endtask

  initial begin
    int idx;
    int firstStall;
    int n;
    logic [7:0] ra;
    logic [7:0] rd;

    burstAddr  = '{8'd30, 8'd30, 8'd30, 8'd31, 8'd30, 8'd31, 8'd30, 8'd30};
    burstDelta = '{8'd100, 8'd100, 8'hA6, 8'd5, 8'h80, 8'd7, 8'd60, 8'hFF};
    driveBus(1'b0, 8'd0, 8'd0);
    rdAddrA = '0;
    rdAddrB = '0;
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("busyInReset", 32'(busyA), 32'd0);
    checkOutput("rdDataInReset", 32'(rdDataA), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("readyAfterResetA", 32'(ifA.upd_ready), 32'd1);
    checkOutput("readyAfterResetB", 32'(ifB.upd_ready), 32'd1);
    checkOutput("initWeightA", 32'(rdDataA), 32'(modelA[0]));
    checkCounters("afterReset");

    // Single update: the write lands on the 3rd edge after acceptance.
    rdAddrA = 8'd5;
    rdAddrB = 8'd5;
    applyStimulus(8'd5, 8'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("appliedBeforeWrite", appliedA, 32'(expAppliedA - 1));
    @(posedge clk); #1;
    checkOutput("rdSameEdgeAsWriteA", 32'(rdDataA), 32'd128);
    checkOutput("rdSameEdgeAsWriteB", 32'(rdDataB), 32'd128);
    checkOutput("appliedAtWrite", appliedA, 32'(expAppliedA));
    @(posedge clk); #1;
    checkOutput("rdAfterWriteA", 32'(rdDataA), 32'd138);
    checkOutput("rdAfterWriteB", 32'(rdDataB), 32'(modelB[5]));

    // Saturation, floor clamps and out-of-range targets.
    for (int i = 0; i < 3; i++) applyStimulus(8'd7, 8'd100);
    applyStimulus(8'd8, 8'h80);
    applyStimulus(8'd255, 8'd9);
    applyStimulus(8'd200, 8'hF0);
    applyStimulus(8'd199, 8'd3);
    waitIdle("drainDirected");
    checkCounters("directed");
    readCheck(8'd7);
    readCheck(8'd8);
    readCheck(8'd199);
    readCheck(8'd200);
    readCheck(8'd255);

    // Held burst: four slots plus two entries drained by the FSM while the burst streams in.
    idx = 0;
    firstStall = -1;
    n = 0;
    while (idx < 8 && n < 100) begin
      driveBus(1'b1, burstAddr[idx], burstDelta[idx]);
      if (ifA.upd_ready) begin
        @(posedge clk); #1;
        modelApply(burstAddr[idx], burstDelta[idx]);
        idx++;
      end else begin
        if (firstStall < 0) firstStall = idx;
        @(posedge clk); #1;
      end
      n++;
    end
    driveBus(1'b0, 8'd0, 8'd0);
    checkOutput("burstAllAccepted", 32'(idx), 32'd8);
    checkOutput("burstFirstStall", 32'(firstStall), 32'd6);
    checkOutput("busyAfterBurst", 32'(busyA), 32'd1);
    waitIdle("drainBurst");
    checkCounters("burst");
    readCheck(8'd30);
    readCheck(8'd31);

    // Reset while the FSM sits in READ with three requests still queued.
    for (int i = 0; i < 5; i++) applyStimulus(8'(40 + i), 8'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetBusy", 32'(busyA), 32'd0);
    checkOutput("asyncResetApplied", appliedA, 32'd0);
    checkOutput("asyncResetReady", 32'(ifA.upd_ready), 32'd1);
    modelReset();
    @(posedge clk); #1;
    checkOutput("rdDataMidReset", 32'(rdDataA), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("busyAfterResetRelease", 32'(busyA), 32'd0);
    checkCounters("afterMidReset");
    readCheck(8'd40);
    readCheck(8'd41);
    readCheck(8'd44);
    readCheck(8'd5);

    // Random traffic concentrated on a few addresses plus the out-of-range band.
    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 11));
      rd = 8'($urandom);
      applyStimulus(ra, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    waitIdle("drainRandom");
    checkCounters("random");
    for (int a = 0; a < 256; a++) readCheck(8'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
